// File: rtl/ws2812_pkg.sv
// Shared constants, pixel layout and FSM state type for the WS2812 serialiser.
// Default timing values assume a 100 MHz clock.
package ws2812_pkg;

    localparam int PIXEL_W = 24;
    localparam int G_MSB   = 23;
    localparam int R_MSB   = 15;
    localparam int B_MSB   = 7;

    localparam int DEF_NUM_LEDS = 60;
    localparam int DEF_T_BIT    = 125;
    localparam int DEF_T0H      = 40;
    localparam int DEF_T1H      = 80;
    localparam int DEF_T_RES    = 30000;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        SEND,
        WAIT,
        LATCH
    } tx_state_t;

endpackage

// File: rtl/ws2812_bit_encoder.sv
// Produces one T_BIT-cycle WS2812 symbol per bit_start: high for T1H or T0H cycles, then low.
// bit_end is asserted during the final cycle so the next bit can start with no gap.
module ws2812_bit_encoder
    import ws2812_pkg::*;
#(
    parameter int T_BIT = DEF_T_BIT,
    parameter int T0H   = DEF_T0H,
    parameter int T1H   = DEF_T1H
) (
    input  logic clk,
    input  logic rst,
    input  logic i_bit_start,
    input  logic i_bit_val,
    output logic o_dout,
    output logic o_bit_end
);

    localparam int CYC_W = $clog2(T_BIT);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(T_BIT - 1);
    localparam logic [CYC_W-1:0] HIGH_0   = CYC_W'(T0H);
    localparam logic [CYC_W-1:0] HIGH_1   = CYC_W'(T1H);

    logic             r_active;
    logic             r_val;
    logic             r_dout;
    logic [CYC_W-1:0] r_cyc;
    logic [CYC_W-1:0] w_cyc_inc;
    logic [CYC_W-1:0] w_high;

    assign w_cyc_inc = r_cyc + 1'b1;
    assign w_high    = r_val ? HIGH_1 : HIGH_0;
    assign o_bit_end = r_active && (r_cyc == CYC_LAST);
    assign o_dout    = r_dout;

    // dout is registered one cycle ahead, so it reflects the cycle index being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_active <= 1'b0;
            r_val    <= 1'b0;
            r_dout   <= 1'b0;
            r_cyc    <= '0;
        end else if (i_bit_start) begin
            r_active <= 1'b1;
            r_val    <= i_bit_val;
            r_cyc    <= '0;
            r_dout   <= 1'b1;
        end else if (r_active) begin
            if (r_cyc == CYC_LAST) begin
                r_active <= 1'b0;
                r_cyc    <= '0;
                r_dout   <= 1'b0;
            end else begin
                r_cyc    <= w_cyc_inc;
                r_dout   <= (w_cyc_inc < w_high);
            end
        end
    end

endmodule

// File: rtl/ws2812_tx.sv
// Frame-level WS2812 transmitter: hold buffer, GRB shifter, pixel/frame counters and latch gap.
// Bits are handed to ws2812_bit_encoder back to back so a frame is one continuous bit stream.
module ws2812_tx
    import ws2812_pkg::*;
#(
    parameter int NUM_LEDS = DEF_NUM_LEDS,
    parameter int T_BIT    = DEF_T_BIT,
    parameter int T0H      = DEF_T0H,
    parameter int T1H      = DEF_T1H,
    parameter int T_RES    = DEF_T_RES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic [PIXEL_W-1:0] i_pixel_data,
    input  logic               i_pixel_valid,
    output logic               o_pixel_ready,
    output logic               o_busy,
    output logic               o_frame_done,
    output logic               o_underrun,
    output logic               o_dout
);

    localparam int CNT_W = $clog2(NUM_LEDS + 1);
    localparam int RES_W = $clog2(T_RES + 1);
    localparam logic [CNT_W-1:0] N_LEDS   = CNT_W'(NUM_LEDS);
    localparam logic [RES_W-1:0] RES_LAST = RES_W'(T_RES - 1);
    localparam logic [4:0]       BIT_TOP  = 5'(PIXEL_W - 1);

    tx_state_t          r_state;
    logic [PIXEL_W-1:0] r_hold;
    logic               r_hold_valid;
    logic [PIXEL_W-1:0] r_shift;
    logic [4:0]         r_bit_idx;
    logic [CNT_W-1:0]   r_accepted;
    logic [CNT_W-1:0]   r_sent;
    logic [RES_W-1:0]   r_res_cnt;
    logic               r_frame_done;
    logic               r_underrun;

    logic               w_pixel_ready;
    logic               w_xfer;
    logic               w_bit_end;
    logic               w_last_bit_end;
    logic               w_frame_end;
    logic               w_load;
    logic               w_next_bit;
    logic               w_bit_start;
    logic               w_bit_val;
    logic [CNT_W-1:0]   w_sent_inc;
    logic [PIXEL_W-1:0] w_hold_grb;

    assign w_hold_grb = {r_hold[G_MSB -: 8], r_hold[R_MSB -: 8], r_hold[B_MSB -: 8]};

    assign w_pixel_ready  = (r_state != IDLE) && !r_hold_valid && (r_accepted != N_LEDS);
    assign w_xfer         = i_pixel_valid && w_pixel_ready;
    assign w_sent_inc     = r_sent + 1'b1;
    assign w_last_bit_end = (r_state == SEND) && w_bit_end && (r_bit_idx == 5'd0);
    assign w_frame_end    = w_last_bit_end && (w_sent_inc == N_LEDS);
    assign w_next_bit     = (r_state == SEND) && w_bit_end && (r_bit_idx != 5'd0);

    // A pixel is pulled from the hold buffer on first fill, on recovery from WAIT,
    // or exactly on the last cycle of the previous pixel so the next bit follows seamlessly.
    assign w_load = r_hold_valid &&
                    ((r_state == FILL) || (r_state == WAIT) || (w_last_bit_end && !w_frame_end));

    assign w_bit_start = w_load || w_next_bit;
    assign w_bit_val   = w_load ? w_hold_grb[PIXEL_W-1] : r_shift[PIXEL_W-1];

    ws2812_bit_encoder #(
        .T_BIT (T_BIT),
        .T0H   (T0H),
        .T1H   (T1H)
    ) u_bit_encoder (
        .clk         (clk),
        .rst         (rst),
        .i_bit_start (w_bit_start),
        .i_bit_val   (w_bit_val),
        .o_dout      (o_dout),
        .o_bit_end   (w_bit_end)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
            r_shift      <= '0;
            r_bit_idx    <= 5'd0;
            r_accepted   <= '0;
            r_sent       <= '0;
            r_res_cnt    <= '0;
            r_frame_done <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;

            // An accept wins over a drain, so a same-cycle reload keeps the new pixel valid.
            if (w_xfer) begin
                r_hold       <= i_pixel_data;
                r_hold_valid <= 1'b1;
                r_accepted   <= r_accepted + 1'b1;
            end else if (w_load) begin
                r_hold_valid <= 1'b0;
            end

            // The shifter holds the bits still to send, left-aligned; the current bit sits in the encoder.
            if (w_load) begin
                r_shift   <= {w_hold_grb[PIXEL_W-2:0], 1'b0};
                r_bit_idx <= BIT_TOP;
            end else if (w_next_bit) begin
                r_shift   <= r_shift << 1;
                r_bit_idx <= r_bit_idx - 5'd1;
            end

            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_state    <= FILL;
                        r_underrun <= 1'b0;
                        r_accepted <= '0;
                        r_sent     <= '0;
                    end
                end
                FILL: begin
                    if (w_load) r_state <= SEND;
                end
                SEND: begin
                    if (w_last_bit_end) begin
                        r_sent <= w_sent_inc;
                        if (w_frame_end) begin
                            r_state   <= LATCH;
                            r_res_cnt <= '0;
                        end else if (!r_hold_valid) begin
                            r_state    <= WAIT;
                            r_underrun <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (w_load) r_state <= SEND;
                end
                LATCH: begin
                    if (r_res_cnt == RES_LAST) begin
                        r_frame_done <= 1'b1;
                        r_state      <= IDLE;
                    end else begin
                        r_res_cnt <= r_res_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_pixel_ready = w_pixel_ready;
    assign o_busy        = (r_state != IDLE);
    assign o_frame_done  = r_frame_done;
    assign o_underrun    = r_underrun;

endmodule
